ex_stage: RTL and testbench

//  RV64IM execute stage, directly downstream of the ID/EX pipeline register. Applies EX/MEM and MEM/WB

---
 rtl/riscv_pkg.sv | 36 +++
 rtl/muldiv_iter.sv | 110 +++++++++++
 rtl/ex_stage.sv | 153 +++++++++++++++
 tb/tb_ex_stage.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the RV64IM execute stage: ALU control codes,
// M-extension func3 codes and the multiply/divide engine states.
package riscv_pkg;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE = 3'b010;
  localparam logic [2:0] ALUOP_ITYPE = 3'b011;
  localparam logic [2:0] ALUOP_IMM   = 3'b100;
  localparam logic [2:0] ALUOP_PCIMM = 3'b101;
  localparam logic [2:0] ALUOP_PC4   = 3'b110;
  localparam logic [2:0] ALUOP_ZERO  = 3'b111;

  localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;

  localparam logic [2:0] M_MUL    = 3'd0;
  localparam logic [2:0] M_MULH   = 3'd1;
  localparam logic [2:0] M_MULHSU = 3'd2;
  localparam logic [2:0] M_MULHU  = 3'd3;
  localparam logic [2:0] M_DIV    = 3'd4;
  localparam logic [2:0] M_DIVU   = 3'd5;
  localparam logic [2:0] M_REM    = 3'd6;
  localparam logic [2:0] M_REMU   = 3'd7;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative radix-2 multiply/divide engine. Works on operand magnitudes,
// one step per BUSY cycle for XLEN cycles, then applies the sign fixup.
// Handshake: a start pulse is accepted only in IDLE; done is high for
// exactly one cycle (DONE) while result is valid.
module muldiv_iter
  import riscv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output md_state_t       state,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  logic [6:0]        step;
  logic [2:0]        f3_q;
  logic [XLEN-1:0]   hi, lo, opnd, dividend;
  logic              neg_res, neg_rem, div_zero;

  logic              a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum, div_trial;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  // signedness of each operand for the op being issued, and its magnitude
  always_comb begin
    a_sgn = (func3 == M_MUL) || (func3 == M_MULH) || (func3 == M_MULHSU) ||
            (func3 == M_DIV) || (func3 == M_REM);
    b_sgn = (func3 == M_MUL) || (func3 == M_MULH) ||
            (func3 == M_DIV) || (func3 == M_REM);
    a_neg = a_sgn && op_a[XLEN-1];
    b_neg = b_sgn && op_b[XLEN-1];
    mag_a = a_neg ? -op_a : op_a;
    mag_b = b_neg ? -op_b : op_b;
  end

  // one step of shift-add multiply and of restoring divide, plus final fixup
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    div_trial = {hi, lo[XLEN-1]} - {1'b0, opnd};
    prod      = {hi, lo};
    prod_fix  = neg_res ? -prod : prod;
    quo_fix   = div_zero ? '1 : (neg_res ? -lo : lo);
    rem_fix   = div_zero ? dividend : (neg_rem ? -hi : hi);
    case (f3_q)
      M_MUL:                      result = prod_fix[XLEN-1:0];
      M_MULH, M_MULHSU, M_MULHU:  result = prod_fix[2*XLEN-1:XLEN];
      M_DIV, M_DIVU:              result = quo_fix;
      default:                    result = rem_fix;
    endcase
  end

  assign busy = (state == BUSY);
  assign done = (state == DONE);

  // IDLE -> BUSY on start, XLEN steps in BUSY, one DONE cycle, back to IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      step     <= '0;
      f3_q     <= '0;
      hi       <= '0;
      lo       <= '0;
      opnd     <= '0;
      dividend <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state    <= BUSY;
          step     <= '0;
          f3_q     <= func3;
          hi       <= '0;
          // divide shifts the dividend out of lo; multiply consumes the multiplier from lo
          lo       <= func3[2] ? mag_a : mag_b;
          opnd     <= func3[2] ? mag_b : mag_a;
          neg_res  <= a_neg ^ b_neg;
          neg_rem  <= a_neg;
          div_zero <= (op_b == '0);
          dividend <= op_a;
        end
        BUSY: begin
          if (f3_q[2]) begin
            if (!div_trial[XLEN]) hi <= div_trial[XLEN-1:0];
            else                  hi <= {hi[XLEN-2:0], lo[XLEN-1]};
            lo <= {lo[XLEN-2:0], ~div_trial[XLEN]};
          end else begin
            hi <= mul_sum[XLEN:1];
            lo <= {mul_sum[0], lo[XLEN-1:1]};
          end
          step <= step + 7'd1;
          if (step == 7'(XLEN-1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ex_stage.sv
// RV64IM execute stage: operand forwarding, single-cycle ALU, iterative
// mul/div glue and the EX/MEM pipeline register. ex_stall holds the
// upstream stages while an M-op is issuing or in flight.
module ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] readdata1,
  input  logic [XLEN-1:0] readdata2,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  input  logic [4:0]      writeregister,
  input  logic [4:0]      regrs1,
  input  logic [4:0]      regrs2,
  input  logic            aluop1,
  input  logic            aluop2,
  input  logic            aluop3,
  input  logic            alusrc,
  input  logic            memread,
  input  logic            memwrite,
  input  logic            memtoreg,
  input  logic            regwrite,
  input  logic [6:0]      func7,
  input  logic [2:0]      func3,
  input  logic [4:0]      exmem_rd,
  input  logic            exmem_regwrite,
  input  logic [XLEN-1:0] exmem_aluresult,
  input  logic [4:0]      memwb_rd,
  input  logic            memwb_regwrite,
  input  logic [XLEN-1:0] memwb_writedata,
  output logic [XLEN-1:0] aluresult_out,
  output logic [XLEN-1:0] writedata_out,
  output logic [4:0]      writeregister_out,
  output logic [2:0]      func3_out,
  output logic            memread_out,
  output logic            memwrite_out,
  output logic            memtoreg_out,
  output logic            regwrite_out,
  output logic            ex_stall
);

  logic [2:0]      aluop;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2, op_b, alu_res, sra_res, md_result;
  logic [5:0]      shamt;
  logic            m_op, issue, md_busy, md_done;
  md_state_t       md_state;

  // M-op control captured at issue; the ID/EX copy is held but forwards drain
  logic [4:0]      lat_rd;
  logic [2:0]      lat_f3;
  logic [XLEN-1:0] lat_wd;
  logic [3:0]      lat_ctrl;

  assign aluop = {aluop3, aluop2, aluop1};

  // forwarding: EX/MEM beats MEM/WB, x0 is never forwarded
  always_comb begin
    if (exmem_regwrite && exmem_rd != 5'd0 && exmem_rd == regrs1)      fwd_rs1 = exmem_aluresult;
    else if (memwb_regwrite && memwb_rd != 5'd0 && memwb_rd == regrs1) fwd_rs1 = memwb_writedata;
    else                                                               fwd_rs1 = readdata1;
    if (exmem_regwrite && exmem_rd != 5'd0 && exmem_rd == regrs2)      fwd_rs2 = exmem_aluresult;
    else if (memwb_regwrite && memwb_rd != 5'd0 && memwb_rd == regrs2) fwd_rs2 = memwb_writedata;
    else                                                               fwd_rs2 = readdata2;
  end

  assign op_b    = alusrc ? imm : fwd_rs2;
  assign shamt   = op_b[5:0];
  assign sra_res = $unsigned($signed(fwd_rs1) >>> shamt);

  // single-cycle ALU
  always_comb begin
    alu_res = '0;
    case (aluop)
      ALUOP_ADD: alu_res = fwd_rs1 + op_b;
      ALUOP_SUB: alu_res = fwd_rs1 - op_b;
      ALUOP_RTYPE, ALUOP_ITYPE: begin
        case (func3)
          F3_ADD:  alu_res = (aluop == ALUOP_RTYPE && func7[5]) ? fwd_rs1 - op_b : fwd_rs1 + op_b;
          F3_SLL:  alu_res = fwd_rs1 << shamt;
          F3_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(fwd_rs1) < $signed(op_b)};
          F3_SLTU: alu_res = {{(XLEN-1){1'b0}}, fwd_rs1 < op_b};
          F3_XOR:  alu_res = fwd_rs1 ^ op_b;
          F3_SR:   alu_res = func7[5] ? sra_res : fwd_rs1 >> shamt;
          F3_OR:   alu_res = fwd_rs1 | op_b;
          default: alu_res = fwd_rs1 & op_b;
        endcase
      end
      ALUOP_IMM:   alu_res = imm;
      ALUOP_PCIMM: alu_res = pc + imm;
      ALUOP_PC4:   alu_res = pc + 64'(4);
      default:     alu_res = '0;
    endcase
  end

  assign m_op     = (aluop == ALUOP_RTYPE) && (func7 == FUNC7_MULDIV);
  assign issue    = m_op && (md_state == IDLE);
  assign ex_stall = issue || md_busy;

  muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (issue),
    .func3  (func3),
    .op_a   (fwd_rs1),
    .op_b   (fwd_rs2),
    .state  (md_state),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );

  // capture the M-op destination, store data and control at issue
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_rd   <= '0;
      lat_f3   <= '0;
      lat_wd   <= '0;
      lat_ctrl <= '0;
    end else if (issue) begin
      lat_rd   <= writeregister;
      lat_f3   <= func3;
      lat_wd   <= fwd_rs2;
      lat_ctrl <= {memread, memwrite, memtoreg, regwrite};
    end
  end

  // EX/MEM register: M-op result on done, bubble while stalled, else ALU path
  always_ff @(posedge clk) begin
    if (rst || (ex_stall && !md_done)) begin
      aluresult_out     <= '0;
      writedata_out     <= '0;
      writeregister_out <= '0;
      func3_out         <= '0;
      {memread_out, memwrite_out, memtoreg_out, regwrite_out} <= '0;
    end else if (md_done) begin
      aluresult_out     <= md_result;
      writedata_out     <= lat_wd;
      writeregister_out <= lat_rd;
      func3_out         <= lat_f3;
      {memread_out, memwrite_out, memtoreg_out, regwrite_out} <= lat_ctrl;
    end else begin
      aluresult_out     <= alu_res;
      writedata_out     <= fwd_rs2;
      writeregister_out <= writeregister;
      func3_out         <= func3;
      {memread_out, memwrite_out, memtoreg_out, regwrite_out} <= {memread, memwrite, memtoreg, regwrite};
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed instruction vectors, a cycle-level reference
// model of the EX/MEM contents and ex_stall, and a queue of hand-computed
// results popped whenever a register-writing result leaves the stage.
module tb_ex_stage;
  import riscv_pkg::*;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [XLEN-1:0] readdata1 = '0, readdata2 = '0, imm = '0, pc = '0;
  logic [4:0]      writeregister = '0, regrs1 = '0, regrs2 = '0;
  logic            aluop1 = 0, aluop2 = 0, aluop3 = 0, alusrc = 0;
  logic            memread = 0, memwrite = 0, memtoreg = 0, regwrite = 0;
  logic [6:0]      func7 = '0;
  logic [2:0]      func3 = '0;
  logic [4:0]      exmem_rd = '0, memwb_rd = '0;
  logic            exmem_regwrite = 0, memwb_regwrite = 0;
  logic [XLEN-1:0] exmem_aluresult = '0, memwb_writedata = '0;
  logic [XLEN-1:0] aluresult_out, writedata_out;
  logic [4:0]      writeregister_out;
  logic [2:0]      func3_out;
  logic            memread_out, memwrite_out, memtoreg_out, regwrite_out, ex_stall;

  // clock/reset block
  always #5 clk = ~clk;

  ex_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .readdata1(readdata1), .readdata2(readdata2), .imm(imm), .pc(pc),
    .writeregister(writeregister), .regrs1(regrs1), .regrs2(regrs2),
    .aluop1(aluop1), .aluop2(aluop2), .aluop3(aluop3), .alusrc(alusrc),
    .memread(memread), .memwrite(memwrite), .memtoreg(memtoreg), .regwrite(regwrite),
    .func7(func7), .func3(func3),
    .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite), .exmem_aluresult(exmem_aluresult),
    .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite), .memwb_writedata(memwb_writedata),
    .aluresult_out(aluresult_out), .writedata_out(writedata_out),
    .writeregister_out(writeregister_out), .func3_out(func3_out),
    .memread_out(memread_out), .memwrite_out(memwrite_out),
    .memtoreg_out(memtoreg_out), .regwrite_out(regwrite_out),
    .ex_stall(ex_stall)
  );

  int checks = 0;
  int errors = 0;
  logic [XLEN-1:0] exp_q[$];

  typedef struct packed {
    logic [63:0] res;
    logic [63:0] wd;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [3:0]  ctrl;
  } exmem_t;

  exmem_t exp_now = '0;
  exmem_t pend = '0;
  int     busy_left = 0;
  bit     live = 0;

  // ---------------- reference model ----------------
  function automatic logic [63:0] fwd_val(input logic [4:0] rs, input logic [63:0] rdv);
    if (exmem_regwrite && exmem_rd != 0 && exmem_rd == rs) return exmem_aluresult;
    if (memwb_regwrite && memwb_rd != 0 && memwb_rd == rs) return memwb_writedata;
    return rdv;
  endfunction

  function automatic logic [63:0] alu_ref(input logic [2:0] aop, input logic [6:0] f7,
                                          input logic [2:0] f3, input logic [63:0] a,
                                          input logic [63:0] b);
    logic [63:0] ob;
    logic signed [63:0] sa;
    int sh;
    ob = alusrc ? imm : b;
    sh = int'(ob % 64);
    sa = a;
    case (aop)
      3'd0: return a + ob;
      3'd1: return a - ob;
      3'd2, 3'd3: begin
        case (f3)
          3'd0: return (aop == 3'd2 && f7[5]) ? a - ob : a + ob;
          3'd1: return a << sh;
          3'd2: return ($signed(a) < $signed(ob)) ? 64'd1 : 64'd0;
          3'd3: return (a < ob) ? 64'd1 : 64'd0;
          3'd4: return a ^ ob;
          3'd5: begin
            if (f7[5]) begin sa = sa >>> sh; return sa; end
            return a >> sh;
          end
          3'd6: return a | ob;
          default: return a & ob;
        endcase
      end
      3'd4: return imm;
      3'd5: return pc + imm;
      3'd6: return pc + 64'd4;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [63:0] m_ref(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] sa, sb, za, zb, p;
    logic [63:0] min_v, ones;
    sa = {{64{a[63]}}, a}; sb = {{64{b[63]}}, b};
    za = {64'd0, a};       zb = {64'd0, b};
    min_v = 64'h8000_0000_0000_0000;
    ones  = '1;
    p = '0;
    case (f3)
      3'd0: begin p = za * zb; return p[63:0]; end
      3'd1: begin p = sa * sb; return p[127:64]; end
      3'd2: begin p = sa * zb; return p[127:64]; end
      3'd3: begin p = za * zb; return p[127:64]; end
      3'd4: begin
        if (b == 0) return ones;
        if (a == min_v && b == ones) return a;
        return $unsigned($signed(a) / $signed(b));
      end
      3'd5: return (b == 0) ? ones : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == min_v && b == ones) return 64'd0;
        return $unsigned($signed(a) % $signed(b));
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit m_in();
    return ({aluop3, aluop2, aluop1} == 3'b010) && (func7 == 7'b0000001);
  endfunction

  // model of the EX/MEM register: advance once per clock from the inputs
  always @(posedge clk) begin
    logic [63:0] a, b;
    a = fwd_val(regrs1, readdata1);
    b = fwd_val(regrs2, readdata2);
    if (rst) begin
      exp_now = '0; busy_left = 0; live = 1;
    end else if (busy_left > 0) begin
      busy_left = busy_left - 1;
      exp_now = (busy_left == 0) ? pend : '0;
    end else if (m_in()) begin
      pend = '{m_ref(func3, a, b), b, writeregister, func3, {memread, memwrite, memtoreg, regwrite}};
      busy_left = XLEN + 1;
      exp_now = '0;
    end else begin
      exp_now = '{alu_ref({aluop3, aluop2, aluop1}, func7, func3, a, b), b, writeregister, func3,
                  {memread, memwrite, memtoreg, regwrite}};
    end
  end

  // scoreboard: outputs every cycle, literal results from exp_q, stall before each edge
  always @(negedge clk) begin
    exmem_t act;
    logic [63:0] lit;
    bit exp_st;
    if (live) begin
      act = '{aluresult_out, writedata_out, writeregister_out, func3_out,
              {memread_out, memwrite_out, memtoreg_out, regwrite_out}};
      checks++;
      if (act !== exp_now) begin
        errors++;
        $display("FAIL exmem t=%0t got=%h want=%h", $time, act, exp_now);
      end
      if (regwrite_out === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL result_unexpected t=%0t got=%h want=none", $time, aluresult_out);
        end else begin
          lit = exp_q.pop_front();
          if (aluresult_out !== lit) begin
            errors++;
            $display("FAIL result t=%0t got=%h want=%h", $time, aluresult_out, lit);
          end
        end
      end
      #3;
      if (!rst) begin
        exp_st = (busy_left > 1) || (busy_left == 0 && m_in());
        checks++;
        if (ex_stall !== exp_st) begin
          errors++;
          $display("FAIL ex_stall t=%0t got=%b want=%b", $time, ex_stall, exp_st);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_instr(input logic [2:0] aop, input logic [6:0] f7, input logic [2:0] f3,
                           input logic src, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [63:0] v1, input logic [63:0] v2,
                           input logic [63:0] iv, input logic rw);
    {aluop3, aluop2, aluop1} = aop;
    func7 = f7; func3 = f3; alusrc = src;
    writeregister = rd; regrs1 = rs1; regrs2 = rs2;
    readdata1 = v1; readdata2 = v2; imm = iv; regwrite = rw;
  endtask

  // present one instruction and hold it until the stage accepts it
  task automatic send(input logic [2:0] aop, input logic [6:0] f7, input logic [2:0] f3,
                      input logic src, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [63:0] v1, input logic [63:0] v2,
                      input logic [63:0] iv, input logic rw, input logic [63:0] lit,
                      output int stalls);
    bit st;
    int n;
    set_instr(aop, f7, f3, src, rd, rs1, rs2, v1, v2, iv, rw);
    if (rw) exp_q.push_back(lit);
    stalls = 0; n = 0;
    do begin
      #2;
      st = ex_stall;
      if (st) stalls++;
      @(negedge clk); #1;
      n++;
    end while (st && n < 200);
    if (st) begin
      checks++; errors++;
      $display("FAIL stall_timeout t=%0t got=stalled want=released", $time);
    end
  endtask

  task automatic mop(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] lit, output int stalls);
    send(3'b010, 7'b0000001, f3, 1'b0, 5'd10, 5'd1, 5'd2, a, b, 64'd0, 1'b1, lit, stalls);
  endtask

  task automatic check_lit(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int st;
    repeat (2) @(negedge clk);
    #1 rst = 0;
    check_lit("reset_stall", {63'd0, ex_stall}, 64'd0);
    check_lit("reset_result", aluresult_out, 64'd0);
    check_lit("reset_regwrite", {63'd0, regwrite_out}, 64'd0);

    // EX/MEM forwarding into both operands
    exmem_rd = 5'd5; exmem_regwrite = 1; exmem_aluresult = 64'h10;
    send(3'b010, 7'd0, 3'd0, 0, 5'd6, 5'd5, 5'd5, 64'd0, 64'd0, 64'd0, 1, 64'h20, st);
    check_lit("alu_latency", 64'(st), 64'd0);

    // EX/MEM beats MEM/WB; MEM/WB alone; rd = 0 never forwards
    memwb_rd = 5'd5; memwb_regwrite = 1; exmem_aluresult = 64'h1; memwb_writedata = 64'h2;
    send(3'b010, 7'd0, 3'd0, 0, 5'd7, 5'd5, 5'd0, 64'h99, 64'd0, 64'd0, 1, 64'h1, st);
    exmem_regwrite = 0;
    send(3'b010, 7'd0, 3'd0, 0, 5'd7, 5'd5, 5'd0, 64'h99, 64'd0, 64'd0, 1, 64'h2, st);
    exmem_regwrite = 1; exmem_rd = 5'd0; memwb_rd = 5'd0;
    send(3'b010, 7'd0, 3'd0, 0, 5'd7, 5'd5, 5'd0, 64'h99, 64'd0, 64'd0, 1, 64'h99, st);

    // store: forwarded rs2 goes to writedata_out, address from imm
    memwb_rd = 5'd5; memwb_regwrite = 1; memwb_writedata = 64'hABCD; memwrite = 1;
    send(3'b000, 7'd0, 3'd3, 1, 5'd0, 5'd1, 5'd5, 64'h100, 64'h7, 64'h8, 0, 64'd0, st);
    memwrite = 0; exmem_regwrite = 0; memwb_regwrite = 0;

    // ALU operations
    send(3'b001, 7'd0, 3'd0, 0, 5'd3, 5'd1, 5'd2, 64'd5, 64'd7, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFE, st);
    send(3'b010, 7'd0, 3'd2, 0, 5'd3, 5'd1, 5'd2, '1, 64'd1, 64'd0, 1, 64'd1, st);
    send(3'b010, 7'd0, 3'd3, 0, 5'd3, 5'd1, 5'd2, '1, 64'd1, 64'd0, 1, 64'd0, st);
    send(3'b010, 7'h20, 3'd5, 0, 5'd3, 5'd1, 5'd2, 64'hFFFF_FFFF_FFFF_FFF0, 64'd2, 64'd0, 1,
         64'hFFFF_FFFF_FFFF_FFFC, st);
    send(3'b010, 7'd0, 3'd1, 0, 5'd3, 5'd1, 5'd2, 64'd1, 64'd68, 64'd0, 1, 64'h10, st);
    send(3'b010, 7'd0, 3'd1, 0, 5'd3, 5'd1, 5'd2, 64'd1, 64'd63, 64'd0, 1, 64'h8000_0000_0000_0000, st);
    send(3'b011, 7'h20, 3'd5, 1, 5'd3, 5'd1, 5'd2, 64'hFFFF_FFFF_FFFF_FFF0, 64'd0, 64'd4, 1, '1, st);
    send(3'b011, 7'd0, 3'd4, 1, 5'd3, 5'd1, 5'd2, 64'h0F, 64'd0, 64'hFF, 1, 64'hF0, st);
    pc = 64'h1000;
    send(3'b100, 7'd0, 3'd0, 1, 5'd3, 5'd1, 5'd2, 64'd9, 64'd9, 64'h1234, 1, 64'h1234, st);
    send(3'b101, 7'd0, 3'd0, 1, 5'd3, 5'd1, 5'd2, 64'd9, 64'd9, 64'h20, 1, 64'h1020, st);
    send(3'b110, 7'd0, 3'd0, 1, 5'd3, 5'd1, 5'd2, 64'd9, 64'd9, 64'h20, 1, 64'h1004, st);
    send(3'b111, 7'd0, 3'd0, 1, 5'd3, 5'd1, 5'd2, 64'd9, 64'd9, 64'h20, 1, 64'h0, st);

    // divide, including special cases; issued back-to-back
    mop(M_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, st);
    check_lit("div_stall_cycles", 64'(st), 64'd65);
    mop(M_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, st);
    mop(M_DIVU, 64'd5, 64'd0, '1, st);
    check_lit("div0_stall_cycles", 64'(st), 64'd65);
    mop(M_REM, 64'd5, 64'd0, 64'd5, st);
    mop(M_DIV, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, st);
    check_lit("ovf_stall_cycles", 64'(st), 64'd65);
    mop(M_REM, 64'h8000_0000_0000_0000, '1, 64'd0, st);
    mop(M_REMU, 64'd100, 64'd7, 64'd2, st);

    // multiply
    mop(M_MULHU, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, st);
    mop(M_MUL, '1, '1, 64'd1, st);
    mop(M_MULH, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, '1, st);
    mop(M_MULHSU, '1, 64'd2, '1, st);
    mop(M_MUL, 64'd3, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFF4, st);

    // reset in the middle of a divide abandons it
    set_instr(3'b010, 7'b0000001, M_DIV, 0, 5'd11, 5'd1, 5'd2, 64'd1000, 64'd3, 64'd0, 1);
    repeat (31) @(negedge clk);
    #1;
    rst = 1;
    set_instr(3'b000, 7'd0, 3'd0, 0, 5'd12, 5'd1, 5'd2, 64'd3, 64'd4, 64'd0, 1);
    @(negedge clk); #1;
    rst = 0;
    check_lit("abort_stall", {63'd0, ex_stall}, 64'd0);
    check_lit("abort_result", aluresult_out, 64'd0);
    check_lit("abort_regwrite", {63'd0, regwrite_out}, 64'd0);
    send(3'b000, 7'd0, 3'd0, 0, 5'd12, 5'd1, 5'd2, 64'd3, 64'd4, 64'd0, 1, 64'd7, st);
    check_lit("post_reset_latency", 64'(st), 64'd0);

    // drain
    set_instr(3'b111, 7'd0, 3'd0, 0, 5'd0, 5'd0, 5'd0, 64'd0, 64'd0, 64'd0, 0);
    repeat (4) @(negedge clk);
    #5;
    check_lit("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
